// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and helpers for the IF/ID/EX/WB pipeline sequencer:
// state codes, stage-control bundle and opcode classification.
package pipeline_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STALL_MC  = 3'd2,
    ST_STALL_MEM = 3'd3,
    ST_FLUSH     = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  localparam int OPC_ABS_FIRST = 13;
  localparam int OPC_ABS_LAST  = 17;
  localparam int ERR_BIT       = 6;

  typedef struct packed {
    logic pc_en;
    logic if_en;
    logic id_en;
    logic ex_en;
    logic wb_en;
    logic id_flush;
    logic ex_flush;
    logic stall;
    logic trap;
  } ctrl_t;

  function automatic logic is_multicycle(input logic [4:0] opcode);
    return (opcode >= 5'(OPC_ABS_FIRST)) && (opcode <= 5'(OPC_ABS_LAST));
  endfunction

  // Every control output is a pure function of the state it is entering.
  function automatic ctrl_t decode_ctrl(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_RUN: begin
        c.pc_en = 1'b1;
        c.if_en = 1'b1;
        c.id_en = 1'b1;
        c.ex_en = 1'b1;
        c.wb_en = 1'b1;
      end
      ST_STALL_MC, ST_STALL_MEM: c.stall = 1'b1;
      ST_FLUSH: begin
        c.pc_en    = 1'b1;
        c.if_en    = 1'b1;
        c.id_en    = 1'b1;
        c.ex_en    = 1'b1;
        c.wb_en    = 1'b1;
        c.id_flush = 1'b1;
        c.ex_flush = 1'b1;
      end
      ST_TRAP: c.trap = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_stall_timer.sv
// Loadable down-counter shared by the multi-cycle stall and the branch flush.
// expire_o flags the last cycle of the interval (count of one).
module pipeline_sequencer_stall_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: stage enables/flushes, multi-cycle and memory stalls,
// branch squashing, error trap and saturating run/stall cycle counters.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int MC_CYCLES   = 4,
  parameter int FLUSH_DEPTH = 2,
  parameter int CW          = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              halt_req_i,
  input  logic [DWIDTH-1:0] id_instr_i,
  input  logic              branch_taken_i,
  input  logic              mem_ready_i,
  input  logic [6:0]        rflags_i,
  output logic              pc_en_o,
  output logic              if_en_o,
  output logic              id_en_o,
  output logic              ex_en_o,
  output logic              wb_en_o,
  output logic              id_flush_o,
  output logic              ex_flush_o,
  output logic              stall_o,
  output logic              trap_o,
  output logic [2:0]        state_o,
  output logic [CW-1:0]     run_cnt_o,
  output logic [CW-1:0]     stall_cnt_o
);

  localparam int TMAX = (MC_CYCLES > FLUSH_DEPTH) ? MC_CYCLES : FLUSH_DEPTH;
  localparam int TW   = $clog2(TMAX + 1);

  state_e          state_q, state_d;
  logic            pend_flush_q, pend_flush_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [CW-1:0]   run_cnt_q, stall_cnt_q;
  logic            tmr_load, tmr_en, tmr_expire;
  logic [TW-1:0]   tmr_value;
  logic [4:0]      opcode;
  logic            err;
  logic            unused_ok;

  assign opcode    = id_instr_i[DWIDTH-1:DWIDTH-5];
  assign err       = rflags_i[ERR_BIT];
  assign unused_ok = ^{id_instr_i[DWIDTH-6:0], rflags_i[ERR_BIT-1:0]};

  pipeline_sequencer_stall_timer #(.W(TW)) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    pend_flush_d = pend_flush_q;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_value    = '0;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (err) begin
          state_d = ST_TRAP;
        end else if (!mem_ready_i) begin
          state_d = ST_STALL_MEM;
          if (branch_taken_i) pend_flush_d = 1'b1;
        end else if (branch_taken_i) begin
          state_d   = ST_FLUSH;
          tmr_load  = 1'b1;
          tmr_value = TW'(FLUSH_DEPTH);
        end else if (is_multicycle(opcode) && ctrl_q.id_en) begin
          state_d   = ST_STALL_MC;
          tmr_load  = 1'b1;
          tmr_value = TW'(MC_CYCLES - 1);
        end else if (halt_req_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL_MC: begin
        if (err) begin
          state_d = ST_TRAP;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expire) state_d = ST_RUN;
        end
      end
      // A branch that resolved while memory was busy is replayed as a flush here.
      ST_STALL_MEM: begin
        if (err) begin
          state_d = ST_TRAP;
        end else if (mem_ready_i) begin
          if (pend_flush_q) begin
            state_d      = ST_FLUSH;
            pend_flush_d = 1'b0;
            tmr_load     = 1'b1;
            tmr_value    = TW'(FLUSH_DEPTH);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        if (!mem_ready_i) begin
          state_d      = ST_STALL_MEM;
          pend_flush_d = 1'b1;
        end else if (branch_taken_i) begin
          tmr_load  = 1'b1;
          tmr_value = TW'(FLUSH_DEPTH);
        end else begin
          tmr_en = 1'b1;
          if (tmr_expire) state_d = ST_RUN;
        end
      end
      ST_TRAP: begin
        pend_flush_d = 1'b0;
        if (start_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      pend_flush_q <= 1'b0;
      ctrl_q       <= '0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
      ctrl_q       <= ctrl_d;
    end
  end

  // Counters hold once saturated and never clear outside reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (((state_q == ST_RUN) || (state_q == ST_FLUSH)) && (run_cnt_q != '1)) begin
        run_cnt_q <= run_cnt_q + CW'(1);
      end
      if (((state_q == ST_STALL_MC) || (state_q == ST_STALL_MEM)) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CW'(1);
      end
    end
  end

  assign pc_en_o     = ctrl_q.pc_en;
  assign if_en_o     = ctrl_q.if_en;
  assign id_en_o     = ctrl_q.id_en;
  assign ex_en_o     = ctrl_q.ex_en;
  assign wb_en_o     = ctrl_q.wb_en;
  assign id_flush_o  = ctrl_q.id_flush;
  assign ex_flush_o  = ctrl_q.ex_flush;
  assign stall_o     = ctrl_q.stall;
  assign trap_o      = ctrl_q.trap;
  assign state_o     = state_q;
  assign run_cnt_o   = run_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: a phase-based behavioural model checked every cycle,
// plus hand-computed literal expectations; a narrow-counter instance exercises saturation.
module tb_pipeline_sequencer;

  localparam int MC_CYCLES   = 4;
  localparam int FLUSH_DEPTH = 2;
  localparam int CW          = 16;
  localparam int CW_SMALL    = 2;

  logic clk, rstN, startI, haltI, brI, memI;
  logic [31:0] idInstr;
  logic [6:0]  rflagsI;

  logic pcEn, ifEn, idEn, exEn, wbEn, idFlush, exFlush, stallO, trapO;
  logic [2:0]    stateO;
  logic [CW-1:0] runCnt, stallCnt;

  logic sPc, sIf, sId, sEx, sWb, sIdF, sExF, sStall, sTrap;
  logic [2:0]          sState;
  logic [CW_SMALL-1:0] sRun, sStallCnt;

  int total = 0;
  int bad   = 0;
  bit checkOn = 0;
  int n, memCyc, flCyc;

  pipeline_sequencer #(.DWIDTH(32), .MC_CYCLES(MC_CYCLES), .FLUSH_DEPTH(FLUSH_DEPTH), .CW(CW)) dut (
    .clk_i(clk), .rst_ni(rstN), .start_i(startI), .halt_req_i(haltI), .id_instr_i(idInstr),
    .branch_taken_i(brI), .mem_ready_i(memI), .rflags_i(rflagsI),
    .pc_en_o(pcEn), .if_en_o(ifEn), .id_en_o(idEn), .ex_en_o(exEn), .wb_en_o(wbEn),
    .id_flush_o(idFlush), .ex_flush_o(exFlush), .stall_o(stallO), .trap_o(trapO),
    .state_o(stateO), .run_cnt_o(runCnt), .stall_cnt_o(stallCnt)
  );

  pipeline_sequencer #(.DWIDTH(32), .MC_CYCLES(MC_CYCLES), .FLUSH_DEPTH(FLUSH_DEPTH), .CW(CW_SMALL)) dutSat (
    .clk_i(clk), .rst_ni(rstN), .start_i(startI), .halt_req_i(haltI), .id_instr_i(idInstr),
    .branch_taken_i(brI), .mem_ready_i(memI), .rflags_i(rflagsI),
    .pc_en_o(sPc), .if_en_o(sIf), .id_en_o(sId), .ex_en_o(sEx), .wb_en_o(sWb),
    .id_flush_o(sIdF), .ex_flush_o(sExF), .stall_o(sStall), .trap_o(sTrap),
    .state_o(sState), .run_cnt_o(sRun), .stall_cnt_o(sStallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model in terms of pipeline phases: remaining stall/flush cycles and memory wait.
  typedef struct {
    int active;
    int trap;
    int mcLeft;
    int memWait;
    int flushLeft;
    int pend;
    int run;
    int stl;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t mdlReset();
    mdl_t m;
    m = '{default: 0};
    return m;
  endfunction

  function automatic int expState(mdl_t m);
    if (m.trap != 0)      return 5;
    if (m.active == 0)    return 0;
    if (m.memWait != 0)   return 3;
    if (m.mcLeft > 0)     return 2;
    if (m.flushLeft > 0)  return 4;
    return 1;
  endfunction

  function automatic mdl_t trapped(mdl_t m);
    m.trap = 1; m.active = 0; m.mcLeft = 0; m.memWait = 0; m.flushLeft = 0; m.pend = 0;
    return m;
  endfunction

  function automatic mdl_t modelNext(mdl_t m);
    mdl_t nx;
    int st, op;
    nx = m;
    st = expState(m);
    op = int'(idInstr[31:27]);
    if (st == 1 || st == 4) nx.run++;
    if (st == 2 || st == 3) nx.stl++;
    if (m.trap != 0) begin
      if (startI) nx.trap = 0;
    end else if (m.active == 0) begin
      if (startI) nx.active = 1;
    end else if (m.memWait != 0) begin
      if (rflagsI[6]) nx = trapped(nx);
      else if (memI) begin
        nx.memWait = 0;
        if (m.pend != 0) begin nx.flushLeft = FLUSH_DEPTH; nx.pend = 0; end
      end
    end else if (m.mcLeft > 0) begin
      if (rflagsI[6]) nx = trapped(nx);
      else nx.mcLeft = m.mcLeft - 1;
    end else if (m.flushLeft > 0) begin
      if (!memI) begin nx.memWait = 1; nx.pend = 1; nx.flushLeft = 0; end
      else if (brI) nx.flushLeft = FLUSH_DEPTH;
      else nx.flushLeft = m.flushLeft - 1;
    end else begin
      if (rflagsI[6]) nx = trapped(nx);
      else if (!memI) begin nx.memWait = 1; if (brI) nx.pend = 1; end
      else if (brI) nx.flushLeft = FLUSH_DEPTH;
      else if (op >= 13 && op <= 17) nx.mcLeft = MC_CYCLES - 1;
      else if (haltI) nx.active = 0;
    end
    return nx;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) mdl <= mdlReset();
    else       mdl <= modelNext(mdl);
  end

  function automatic int sat(int v, int w);
    int cap;
    cap = (1 << w) - 1;
    return (v > cap) ? cap : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic hl, input logic [4:0] op,
                               input logic br, input logic mr, input logic er);
    startI  = st;
    haltI   = hl;
    idInstr = {op, 27'h1234567};
    brI     = br;
    memI    = mr;
    rflagsI = {er, 6'b101010};
    @(negedge clk);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    startI = 1'b0; haltI = 1'b0; brI = 1'b0; memI = 1'b1;
    idInstr = {5'd1, 27'h0}; rflagsI = 7'd0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checkOn) begin : cmp
      int st;
      logic en, fl, sl, tp;
      st = expState(mdl);
      en = (st == 1) || (st == 4);
      fl = (st == 4);
      sl = (st == 2) || (st == 3);
      tp = (st == 5);
      checkOutput("state", 32'(stateO), 32'(st));
      checkOutput("ctrl", {23'd0, pcEn, ifEn, idEn, exEn, wbEn, idFlush, exFlush, stallO, trapO},
                  {23'd0, en, en, en, en, en, fl, fl, sl, tp});
      checkOutput("run_cnt", 32'(runCnt), 32'(sat(mdl.run, CW)));
      checkOutput("stall_cnt", 32'(stallCnt), 32'(sat(mdl.stl, CW)));
      checkOutput("sat_run_cnt", 32'(sRun), 32'(sat(mdl.run, CW_SMALL)));
      checkOutput("sat_stall_cnt", 32'(sStallCnt), 32'(sat(mdl.stl, CW_SMALL)));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    doReset();
    checkOn = 1'b1;
    checkOutput("rst_state", 32'(stateO), 32'd0);
    checkOutput("rst_ctrl", {23'd0, pcEn, ifEn, idEn, exEn, wbEn, idFlush, exFlush, stallO, trapO}, 32'd0);

    $display("[TB] scenario 1: ALU stream");
    applyStimulus(1, 0, 5'd1, 0, 1, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 5'd1, 0, 1, 0);
    checkOutput("s1_state", 32'(stateO), 32'd1);
    checkOutput("s1_enables", {27'd0, pcEn, ifEn, idEn, exEn, wbEn}, 32'h1f);
    checkOutput("s1_run_cnt", 32'(runCnt), 32'd10);
    checkOutput("s1_stall_cnt", 32'(stallCnt), 32'd0);
    checkOutput("s1_model_run", 32'(mdl.run), 32'd10);
    checkOutput("s1_sat_run", 32'(sRun), 32'd3);

    $display("[TB] scenario 2: multi-cycle opcode, halt held during stall");
    doReset();
    applyStimulus(1, 0, 5'd1, 0, 1, 0);
    applyStimulus(0, 0, 5'd14, 0, 1, 0);
    checkOutput("s2_enter_mc", 32'(stateO), 32'd2);
    checkOutput("s2_pc_ex_off", {30'd0, pcEn, exEn}, 32'd0);
    n = 0;
    while (stateO == 3'd2 && n < 10) begin
      n++;
      applyStimulus(0, 1, 5'd1, 0, 1, 0);
    end
    checkOutput("s2_mc_cycles", 32'(n), 32'd3);
    checkOutput("s2_back_run", 32'(stateO), 32'd1);
    checkOutput("s2_stall_cnt", 32'(stallCnt), 32'd3);
    applyStimulus(0, 1, 5'd1, 0, 1, 0);
    checkOutput("s2_halt_idle", 32'(stateO), 32'd0);

    $display("[TB] scenario 3: branch flush and branch+multicycle");
    doReset();
    applyStimulus(1, 0, 5'd1, 0, 1, 0);
    applyStimulus(0, 0, 5'd1, 1, 1, 0);
    checkOutput("s3_flush_bits", {30'd0, idFlush, exFlush}, 32'd3);
    n = 0;
    while (stateO == 3'd4 && n < 10) begin
      n++;
      applyStimulus(0, 0, 5'd1, 0, 1, 0);
    end
    checkOutput("s3_flush_cycles", 32'(n), 32'd2);
    checkOutput("s3_back_run", 32'(stateO), 32'd1);
    applyStimulus(0, 0, 5'd15, 1, 1, 0);
    checkOutput("s3_branch_wins", 32'(stateO), 32'd4);
    n = 0;
    while (stateO == 3'd4 && n < 10) begin
      n++;
      applyStimulus(0, 0, 5'd1, 0, 1, 0);
    end
    checkOutput("s3_flush_cycles2", 32'(n), 32'd2);
    checkOutput("s3_no_mc_stall", 32'(stallCnt), 32'd0);

    $display("[TB] scenario 4: memory wait with pending branch");
    doReset();
    applyStimulus(1, 0, 5'd1, 0, 1, 0);
    memCyc = 0;
    flCyc  = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 5'd1, (k == 0), (k >= 5), 0);
      if (stateO == 3'd3) memCyc++;
      else if (stateO == 3'd4) flCyc++;
    end
    checkOutput("s4_mem_cycles", 32'(memCyc), 32'd5);
    checkOutput("s4_flush_cycles", 32'(flCyc), 32'd2);
    checkOutput("s4_final_run", 32'(stateO), 32'd1);
    checkOutput("s4_stall_cnt", 32'(stallCnt), 32'd5);
    checkOutput("s4_sat_stall", 32'(sStallCnt), 32'd3);

    $display("[TB] scenario 5: trap and recovery");
    doReset();
    applyStimulus(1, 0, 5'd1, 0, 1, 0);
    applyStimulus(0, 0, 5'd14, 0, 1, 0);
    applyStimulus(0, 0, 5'd1, 0, 1, 1);
    checkOutput("s5_trap_state", 32'(stateO), 32'd5);
    checkOutput("s5_trap_ctrl", {23'd0, pcEn, ifEn, idEn, exEn, wbEn, idFlush, exFlush, stallO, trapO}, 32'd1);
    applyStimulus(0, 1, 5'd1, 0, 1, 0);
    checkOutput("s5_trap_holds", 32'(stateO), 32'd5);
    applyStimulus(1, 0, 5'd1, 0, 1, 0);
    checkOutput("s5_to_idle", 32'(stateO), 32'd0);
    applyStimulus(1, 0, 5'd1, 0, 1, 0);
    checkOutput("s5_to_run", 32'(stateO), 32'd1);
    applyStimulus(0, 0, 5'd1, 0, 1, 1);
    checkOutput("s5_run_trap", 32'(stateO), 32'd5);

    $display("[TB] scenario 6: asynchronous reset during memory wait");
    doReset();
    applyStimulus(1, 0, 5'd1, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 5'd1, 0, 1, 0);
    applyStimulus(0, 0, 5'd1, 0, 0, 0);
    applyStimulus(0, 0, 5'd1, 0, 0, 0);
    checkOutput("s6_in_mem", {31'd0, stallO}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("s6_rst_state", 32'(stateO), 32'd0);
    checkOutput("s6_rst_ctrl", {23'd0, pcEn, ifEn, idEn, exEn, wbEn, idFlush, exFlush, stallO, trapO}, 32'd0);
    checkOutput("s6_rst_cnts", {runCnt, stallCnt}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1, 0, 5'd1, 0, 1, 0);
    applyStimulus(0, 0, 5'd1, 0, 1, 0);
    checkOutput("s6_restart", 32'(stateO), 32'd1);

    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
